// File: rtl/ram_ctrl_pkg.sv
// Shared FSM state encoding and read/write command constants for the RAM controller.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic logic is_write(input logic rw);
        return rw == RW_WRITE;
    endfunction

endpackage

// File: rtl/ram_ctrl_addr_gen.sv
// Burst beat counter and base+k address generator; latches base/len on load_i.
// Macro RAM_CTRL_BURST_EN enables multi-beat reads; otherwise every read is one beat.
module ram_ctrl_addr_gen
    import ram_ctrl_pkg::*;
#(
    parameter int a_width = 8
) (
    input  logic               clk_i,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [a_width-1:0] base_i,
    input  logic [1:0]         len_i,
    output logic [a_width-1:0] next_addr_o,
    output logic               last_o
);

    logic [a_width-1:0] base_q, base_d;

`ifdef RAM_CTRL_BURST_EN
    logic [1:0] len_q, len_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            base_d = base_i;
            len_d  = len_i;
            cnt_d  = 2'd0;
        end else if (step_i && !last_o) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            base_q <= '0;
            len_q  <= 2'd0;
            cnt_q  <= 2'd0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last_o = (cnt_q == len_q);
    // Address of the beat after the current one; the add wraps at 2**a_width.
    assign next_addr_o = base_q + a_width'(cnt_q) + a_width'(1);
`else
    logic unused_len_step;
    assign unused_len_step = ^{len_i, step_i};

    always_comb begin
        base_d = base_q;
        if (load_i) begin
            base_d = base_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    assign last_o      = 1'b1;
    assign next_addr_o = base_q;
`endif

endmodule

// File: rtl/ram_ctrl.sv
// Single-port RAM controller: one-word writes, 1-4 word read bursts, one rsp pulse per word/ack.
// Macro RAM_CTRL_BURST_EN enables read bursts; without it req_len is ignored and reads are one word.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int d_width = 8,
    parameter int a_width = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_rw,
    input  logic [a_width-1:0] req_addr,
    input  logic [d_width-1:0] req_wdata,
    input  logic [1:0]         req_len,
    output logic               rsp_valid,
    output logic [d_width-1:0] rsp_rdata,
    output logic               rsp_last,
    output logic               ram_enab,
    output logic               ram_rw,
    output logic [a_width-1:0] ram_addr,
    output logic [d_width-1:0] ram_wdata,
    input  logic [d_width-1:0] ram_rdata,
    output logic               ram_clr_n
);

    state_e             state_q, state_d;
    logic               ram_enab_q, ram_enab_d;
    logic               ram_rw_q, ram_rw_d;
    logic [a_width-1:0] ram_addr_q, ram_addr_d;
    logic [d_width-1:0] ram_wdata_q, ram_wdata_d;
    logic               cap_vld_q, cap_vld_d;
    logic               cap_last_q, cap_last_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_last_q, rsp_last_d;
    logic [d_width-1:0] rsp_rdata_q, rsp_rdata_d;

    logic               accept;
    logic               step;
    logic [a_width-1:0] next_addr;
    logic               beat_last;

    ram_ctrl_addr_gen #(
        .a_width (a_width)
    ) u_addr_gen (
        .clk_i       (clk),
        .clr_i       (clr),
        .load_i      (accept),
        .step_i      (step),
        .base_i      (req_addr),
        .len_i       (req_len),
        .next_addr_o (next_addr),
        .last_o      (beat_last)
    );

    always_comb begin
        state_d     = state_q;
        ram_enab_d  = 1'b0;
        ram_rw_d    = RW_READ;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cap_vld_d   = 1'b0;
        cap_last_d  = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        accept      = 1'b0;
        step        = 1'b0;

        // RAM data_out is only driven the cycle after a read issue; sample it only then.
        if (cap_vld_q) begin
            rsp_valid_d = 1'b1;
            rsp_last_d  = cap_last_q;
            rsp_rdata_d = ram_rdata;
        end

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept      = 1'b1;
                    ram_enab_d  = 1'b1;
                    ram_rw_d    = req_rw;
                    ram_addr_d  = req_addr;
                    ram_wdata_d = req_wdata;
                    state_d     = is_write(req_rw) ? WRITE : READ;
                end
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_last_d  = 1'b1;
                rsp_rdata_d = '0;
                state_d     = DRAIN;
            end
            READ: begin
                cap_vld_d  = 1'b1;
                cap_last_d = beat_last;
                if (beat_last) begin
                    state_d = DRAIN;
                end else begin
                    step       = 1'b1;
                    ram_enab_d = 1'b1;
                    ram_rw_d   = RW_READ;
                    ram_addr_d = next_addr;
                end
            end
            DRAIN: begin
                // Leave once the final response is on the bus so ready follows it directly.
                if (rsp_valid_q && rsp_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            ram_enab_q  <= 1'b0;
            ram_rw_q    <= RW_READ;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cap_vld_q   <= 1'b0;
            cap_last_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ram_enab_q  <= ram_enab_d;
            ram_rw_q    <= ram_rw_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cap_vld_q   <= cap_vld_d;
            cap_last_q  <= cap_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_enab  = ram_enab_q;
    assign ram_rw    = ram_rw_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_clr_n = ~clr;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural one-cycle-latency RAM; build with or without RAM_CTRL_BURST_EN.
module tb_ram_ctrl;

`ifdef RAM_CTRL_BURST_EN
    localparam int BL  = 4;
    localparam int BL2 = 2;
`else
    localparam int BL  = 1;
    localparam int BL2 = 1;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic [1:0] req_len = 2'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_last;
    logic       ram_enab;
    logic       ram_rw;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       ram_clr_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_last  (rsp_last),
        .ram_enab  (ram_enab),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_clr_n (ram_clr_n)
    );

    // RAM model: registered read data; 8'hEE stands in for the floating bus when not reading.
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (!ram_clr_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            ram_rdata <= 8'hEE;
        end else if (ram_enab && ram_rw) begin
            mem[ram_addr] <= ram_wdata;
            ram_rdata <= 8'hEE;
        end else if (ram_enab) begin
            ram_rdata <= mem[ram_addr];
        end else begin
            ram_rdata <= 8'hEE;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!req_ready) begin
            n_err++;
            $display("FAIL wait_ready: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
    endtask

    task automatic send(input logic rw, input logic [7:0] addr, input logic [7:0] wd, input logic [1:0] len);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wd;
        req_len   = len;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] wd);
        wait_ready();
        send(1'b1, addr, wd, 2'd0);
        repeat (2) @(negedge clk);
        wait_ready();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp += 9;
        if (ram_clr_n !== 1'b0) begin n_err++; $display("FAIL reset_clr_n: got %b want 0", ram_clr_n); end
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        if (ram_enab !== 1'b0)  begin n_err++; $display("FAIL reset_enab: got %b want 0", ram_enab); end
        if (ram_rw !== 1'b0)    begin n_err++; $display("FAIL reset_rw: got %b want 0", ram_rw); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        if (rsp_last !== 1'b0)  begin n_err++; $display("FAIL reset_rsp_last: got %b want 0", rsp_last); end
        if (ram_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h want 00", ram_addr); end
        if (ram_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata: got %h want 00", ram_wdata); end
        if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", rsp_rdata); end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ram_clr_n !== 1'b1) begin n_err++; $display("FAIL post_reset_clr_n: got %b want 1", ram_clr_n); end
    endtask

    task automatic test_write();
        send(1'b1, 8'h10, 8'h5A, 2'd3);
        @(negedge clk);
        n_cmp += 6;
        if (ram_enab !== 1'b1)  begin n_err++; $display("FAIL wr_enab_t1: got %b want 1", ram_enab); end
        if (ram_rw !== 1'b1)    begin n_err++; $display("FAIL wr_rw_t1: got %b want 1", ram_rw); end
        if (ram_addr !== 8'h10) begin n_err++; $display("FAIL wr_addr_t1: got %h want 10", ram_addr); end
        if (ram_wdata !== 8'h5A) begin n_err++; $display("FAIL wr_wdata_t1: got %h want 5a", ram_wdata); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_rsp_t1: got %b want 0", rsp_valid); end
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_t1: got %b want 0", req_ready); end
        @(negedge clk);
        n_cmp += 4;
        if (ram_enab !== 1'b0)  begin n_err++; $display("FAIL wr_enab_t2: got %b want 0", ram_enab); end
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL wr_rsp_valid_t2: got %b want 1", rsp_valid); end
        if (rsp_last !== 1'b1)  begin n_err++; $display("FAIL wr_rsp_last_t2: got %b want 1", rsp_last); end
        if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL wr_rsp_rdata_t2: got %h want 00", rsp_rdata); end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_rsp_t3: got %b want 0", rsp_valid); end
        wait_ready();
    endtask

    task automatic test_read_single();
        send(1'b0, 8'h10, 8'h00, 2'd0);
        @(negedge clk);
        n_cmp += 3;
        if (ram_enab !== 1'b1)  begin n_err++; $display("FAIL rd_enab_t1: got %b want 1", ram_enab); end
        if (ram_rw !== 1'b0)    begin n_err++; $display("FAIL rd_rw_t1: got %b want 0", ram_rw); end
        if (ram_addr !== 8'h10) begin n_err++; $display("FAIL rd_addr_t1: got %h want 10", ram_addr); end
        @(negedge clk);
        n_cmp += 2;
        if (ram_enab !== 1'b0)  begin n_err++; $display("FAIL rd_enab_t2: got %b want 0", ram_enab); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_t2: got %b want 0", rsp_valid); end
        @(negedge clk);
        n_cmp += 4;
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_rsp_valid_t3: got %b want 1", rsp_valid); end
        if (rsp_last !== 1'b1)  begin n_err++; $display("FAIL rd_rsp_last_t3: got %b want 1", rsp_last); end
        if (rsp_rdata !== 8'h5A) begin n_err++; $display("FAIL rd_rdata_t3: got %h want 5a", rsp_rdata); end
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL rd_ready_t3: got %b want 0", req_ready); end
        @(negedge clk);
        n_cmp += 2;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready_t4: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_rsp_t4: got %b want 0", rsp_valid); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] ea;
        do_write(8'hFE, 8'h01);
        do_write(8'hFF, 8'h02);
        do_write(8'h00, 8'h03);
        do_write(8'h01, 8'h04);
        send(1'b0, 8'hFE, 8'h00, 2'd3);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            ea = 8'hFE + 8'(c - 1);
            n_cmp += 3;
            if (ram_enab !== (c <= BL)) begin n_err++; $display("FAIL burst_enab c%0d: got %b want %b", c, ram_enab, (c <= BL)); end
            if (rsp_valid !== (c >= 3 && c <= BL + 2)) begin n_err++; $display("FAIL burst_rsp_valid c%0d: got %b", c, rsp_valid); end
            if (req_ready !== (c >= BL + 3)) begin n_err++; $display("FAIL burst_ready c%0d: got %b", c, req_ready); end
            if (c <= BL) begin
                n_cmp++;
                if (ram_addr !== ea) begin n_err++; $display("FAIL burst_addr c%0d: got %h want %h", c, ram_addr, ea); end
            end
            if (c >= 3 && c <= BL + 2) begin
                n_cmp += 2;
                if (rsp_rdata !== 8'(c - 2)) begin n_err++; $display("FAIL burst_rdata c%0d: got %h want %h", c, rsp_rdata, 8'(c - 2)); end
                if (rsp_last !== (c == BL + 2)) begin n_err++; $display("FAIL burst_last c%0d: got %b", c, rsp_last); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_en, exp_rv, exp_rdy;
        logic [7:0] ea, ed;
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 8'h00;
        req_len   = 2'd1;
        for (int c = 1; c <= 2 * BL2 + 6; c++) begin
            @(negedge clk);
            exp_en  = (c <= BL2) || (c >= BL2 + 4 && c <= 2 * BL2 + 3);
            exp_rv  = (c >= 3 && c <= BL2 + 2) || (c >= BL2 + 6 && c <= 2 * BL2 + 5);
            exp_rdy = (c == BL2 + 3) || (c == 2 * BL2 + 6);
            ea = (c <= BL2) ? 8'(c - 1) : 8'(c - BL2 - 4);
            ed = (c <= BL2 + 2) ? 8'(c) : 8'(c - BL2 - 3);
            n_cmp += 3;
            if (ram_enab !== exp_en)   begin n_err++; $display("FAIL b2b_enab c%0d: got %b want %b", c, ram_enab, exp_en); end
            if (rsp_valid !== exp_rv)  begin n_err++; $display("FAIL b2b_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rv); end
            if (req_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_ready c%0d: got %b want %b", c, req_ready, exp_rdy); end
            if (exp_en) begin
                n_cmp++;
                if (ram_addr !== ea) begin n_err++; $display("FAIL b2b_addr c%0d: got %h want %h", c, ram_addr, ea); end
            end
            if (exp_rv) begin
                n_cmp++;
                if (rsp_rdata !== ed) begin n_err++; $display("FAIL b2b_rdata c%0d: got %h want %h", c, rsp_rdata, ed); end
            end
            if (c == BL2 + 4) req_valid = 1'b0;
        end
    endtask

    task automatic test_clear_mid_burst();
        send(1'b0, 8'hFE, 8'h00, 2'd3);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (ram_enab !== (BL >= 2)) begin n_err++; $display("FAIL clr_enab_t2: got %b want %b", ram_enab, (BL >= 2)); end
        clr = 1'b1;
        @(negedge clk);
        n_cmp += 4;
        if (ram_clr_n !== 1'b0) begin n_err++; $display("FAIL clr_clr_n: got %b want 0", ram_clr_n); end
        if (ram_enab !== 1'b0)  begin n_err++; $display("FAIL clr_enab_t3: got %b want 0", ram_enab); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL clr_rsp_t3: got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL clr_ready_t3: got %b want 1", req_ready); end
        clr = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            n_cmp += 2;
            if (ram_enab !== 1'b0)  begin n_err++; $display("FAIL clr_enab c%0d: got %b want 0", c, ram_enab); end
            if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL clr_rsp c%0d: got %b want 0", c, rsp_valid); end
        end
        for (int k = 0; k < 2; k++) begin
            wait_ready();
            send(1'b0, (k == 0) ? 8'h10 : 8'hFE, 8'h00, 2'd0);
            repeat (3) @(negedge clk);
            n_cmp += 2;
            if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL clr_read%0d_valid: got %b want 1", k, rsp_valid); end
            if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL clr_read%0d_rdata: got %h want 00", k, rsp_rdata); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_single();
        test_burst_wrap();
        wait_ready();
        test_back_to_back();
        wait_ready();
        test_clear_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter d_width, default 8, data word width.
REQ-002 SHALL have parameter a_width, default 8, address width; RAM depth 2**a_width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request offered.
REQ-006 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 SHALL have port req_rw  input  1  0 = read, 1 = write.
REQ-008 SHALL have port req_addr  input  a_width  base address.
REQ-009 SHALL have port req_wdata  input  d_width  write data.
REQ-010 SHALL have port req_len  input  2  read burst length minus one (1-4 words).
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response pulse per word or write ack.
REQ-012 SHALL have port rsp_rdata  output  d_width  read word; 0 on write ack.
REQ-013 SHALL have port rsp_last  output  1  final response of the request.
REQ-014 SHALL have ports ram_enab, ram_rw (output 1), ram_addr (output a_width) and ram_wdata (output d_width), driving the RAM enable, rw, Addr and data_in pins.
REQ-015 SHALL have port ram_rdata  input  d_width  RAM data_out, registered in the RAM with one-cycle read latency.
REQ-016 SHALL have port ram_clr_n  output  1  RAM active-low clear, equal to ~clr.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ and DRAIN; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on an edge T when state = IDLE and req_valid = 1, latching rw, addr, wdata and len; req_valid SHALL be ignored when req_ready = 0.
REQ-019 SHALL, for a write, drive ram_enab = 1 and ram_rw = 1 with the latched addr/wdata for exactly the cycle after T, pulse rsp_valid = rsp_last = 1 in cycle T+2, then return to IDLE.
REQ-020 SHALL, for a read, issue ram_enab = 1 and ram_rw = 0 in cycles T+1 through T+L (L = req_len+1), with ram_addr = (base+k) mod 2**a_width on beat k.
REQ-021 SHALL register ram_rdata one cycle after each issue cycle and present it with rsp_valid = 1 two cycles after issue; read responses occupy cycles T+3 through T+L+2, with rsp_last on the final one.
REQ-022 SHALL enter DRAIN after the last read issue and reach IDLE so that req_ready = 1 in the cycle after the final rsp_valid.
REQ-023 SHALL ignore req_len for writes, which are always single-word.
REQ-024 SHALL hold ram_enab = 0 whenever not issuing, and SHALL never capture ram_rdata except in the cycle after an issue, because the RAM output is high-Z when disabled.
REQ-025 SHALL use registered outputs for all ram_* signals except ram_clr_n, and SHALL wrap addresses silently (0xFF+1 -> 0x00 at a_width = 8).
REQ-026 SHALL NOT provide response backpressure; rsp_valid pulses unconditionally.

Reset
REQ-027 SHALL, with clr = 1 at an edge, set state IDLE, req_ready = 1 and ram_enab = ram_rw = rsp_valid = rsp_last = 0, and clear ram_addr, ram_wdata, rsp_rdata and the beat counter to 0.
REQ-028 SHALL abort any burst when clr is asserted mid-operation, with no further rsp_valid for the aborted request.
REQ-029 SHALL drive ram_clr_n low for every cycle clr is high, clearing RAM contents.

Configuration
REQ-030 SHALL, with RAM_CTRL_BURST_EN defined, honour req_len for reads as specified above.
REQ-031 SHALL, without RAM_CTRL_BURST_EN, treat every read as L = 1, leave req_len unused and omit the beat counter.

Structure
REQ-032 SHALL take the state enum (IDLE/WRITE/READ/DRAIN) and the RW_READ = 0 / RW_WRITE = 1 constants from shared package ram_ctrl_pkg.
REQ-033 SHALL place the beat counter and base+k address adder in sub-module ram_ctrl_addr_gen.

Verification
REQ-034 SHALL verify: write 0x5A to 0x10 -> ram_enab = 1, ram_rw = 1, ram_addr = 0x10 and ram_wdata = 0x5A for one cycle at T+1; ack rsp_valid = rsp_last = 1 at T+2.
REQ-035 SHALL verify: single read of 0x10 after the write -> rsp_rdata = 0x5A with rsp_valid and rsp_last at T+3; req_ready = 1 at T+4.
REQ-036 SHALL verify: burst read at 0xFE with len = 3 (RAM preloaded 0xFE = 1, 0xFF = 2, 0x00 = 3, 0x01 = 4) -> addresses FE, FF, 00, 01 at T+1..T+4; responses 1, 2, 3, 4 at T+3..T+6; rsp_last only at T+6.
REQ-037 SHALL verify: req_valid held high during a burst -> the second request is not accepted until req_ready returns, and no overlapping ram_enab occurs.
REQ-038 SHALL verify: clr at T+2 of a 4-word burst -> ram_enab = 0 and no rsp_valid from the following cycle; ram_clr_n = 0 while clr is high; RAM reads 0 afterwards.
REQ-039 SHALL verify: build without RAM_CTRL_BURST_EN, read with len = 3 -> exactly one issue and one rsp_valid with rsp_last = 1.
